// File: rtl/ysyx_23060025_pc_gen_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_pc_gen_pkg
// Shared definitions for the PC generator and its redirect arbiter:
//   - PC FSM state encoding (HOLD / ISSUE / WAIT, 2 bits)
//   - default reset PC and sequential instruction step
// Optional build macro used by the top: YSYX_23060025_PC_TRACE_EN
// ----------------------------------------------------------------------------
package ysyx_23060025_pc_gen_pkg;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'b00,
      PC_ISSUE = 2'b01,
      PC_WAIT  = 2'b10
   } pc_state_e;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;
   localparam int unsigned PC_INST_BYTES    = 4;

endpackage

// File: rtl/ysyx_23060025_redir_arb.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_redir_arb
// Fixed-priority arbiter over N redirect channels; index 0 wins. Purely
// combinational so it can be shared with other redirect sources.
// Ports:
//   valid_i     [N]   per-channel request
//   target_i    [N*W] packed targets, channel k at [k*W +: W]
//   any_valid_o       at least one request present
//   grant_o     [N]   one-hot grant of the winning channel
//   target_o    [W]   target of the winning channel (0 when none)
// ----------------------------------------------------------------------------
module ysyx_23060025_redir_arb #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 32
) (
   input  logic [N-1:0]   valid_i,
   input  logic [N*W-1:0] target_i,
   output logic           any_valid_o,
   output logic [N-1:0]   grant_o,
   output logic [W-1:0]   target_o
);

   // Scan from the lowest priority upward so the lowest index overwrites last.
   always_comb begin
      grant_o  = '0;
      target_o = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (valid_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            target_o   = target_i[k*W +: W];
         end
      end
   end

   assign any_valid_o = |valid_i;

endmodule

// File: rtl/ysyx_23060025_pc_gen.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_pc_gen
// Next-PC generator for the IFU. Issues pc_o over a valid/ready handshake,
// waits for fetch completion, then commits the next PC chosen from a
// same-cycle redirect, a captured (pending) redirect, or pc_o + INST_BYTES.
// Ports:
//   clock, reset       clock; synchronous active-low reset
//   redir_valid_i      per-channel redirect request (index 0 highest)
//   redir_target_i     packed redirect targets
//   redir_ack_o        one-hot ack of the channel taken this cycle
//   fetch_valid_o      pc_o valid towards IFU
//   fetch_ready_i      IFU accepts pc_o
//   fetch_done_i       IFU finished the current fetch
//   pc_o               current PC
//   pc_next_o          PC committed if the fetch completes this cycle
//   misalign_o         commit-cycle pulse: target had nonzero low bits
// ----------------------------------------------------------------------------
module ysyx_23060025_pc_gen
   import ysyx_23060025_pc_gen_pkg::*;
#(
   parameter int unsigned          ADDR_LEN   = 32,
   parameter int unsigned          NUM_REDIR  = 3,
   parameter logic [ADDR_LEN-1:0]  RESET_PC   = PC_RESET_DEFAULT,
   parameter int unsigned          INST_BYTES = PC_INST_BYTES
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REDIR-1:0]          redir_valid_i,
   input  logic [NUM_REDIR*ADDR_LEN-1:0] redir_target_i,
   output logic [NUM_REDIR-1:0]          redir_ack_o,
   output logic                          fetch_valid_o,
   input  logic                          fetch_ready_i,
   input  logic                          fetch_done_i,
   output logic [ADDR_LEN-1:0]           pc_o,
   output logic [ADDR_LEN-1:0]           pc_next_o,
   output logic                          misalign_o
);

   localparam logic [ADDR_LEN-1:0] LOW_MASK = ADDR_LEN'(INST_BYTES - 1);
   localparam logic [ADDR_LEN-1:0] STEP     = ADDR_LEN'(INST_BYTES);

   pc_state_e             state_q, state_d;
   logic [ADDR_LEN-1:0]   pc_q, pc_d;
   logic                  pend_v_q, pend_v_d;
   logic [ADDR_LEN-1:0]   pend_t_q, pend_t_d;

   logic                  arb_any;
   logic [NUM_REDIR-1:0]  arb_grant;
   logic [ADDR_LEN-1:0]   arb_target;

   logic                  live;
   logic                  redir_hit;
   logic                  commit;
   logic [ADDR_LEN-1:0]   raw_next;
   logic [ADDR_LEN-1:0]   pc_next;

   ysyx_23060025_redir_arb #(
      .N (NUM_REDIR),
      .W (ADDR_LEN)
   ) u_arb (
      .valid_i     (redir_valid_i),
      .target_i    (redir_target_i),
      .any_valid_o (arb_any),
      .grant_o     (arb_grant),
      .target_o    (arb_target)
   );

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state_q <= PC_HOLD;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         PC_HOLD:  state_d = PC_ISSUE;
         PC_ISSUE: if (fetch_ready_i) state_d = PC_WAIT;
         PC_WAIT:  if (fetch_done_i)  state_d = PC_ISSUE;
         default:  state_d = PC_HOLD;
      endcase
   end

   // Output / control decode
   always_comb begin
      fetch_valid_o = (state_q == PC_ISSUE);
      // Redirects are only taken once the FSM has left HOLD, never in reset.
      live          = reset && (state_q != PC_HOLD);
      commit        = reset && (state_q == PC_WAIT) && fetch_done_i;
   end

   assign redir_hit = live && arb_any;

   // A live redirect beats the pending entry, which beats sequential flow.
   always_comb begin
      if (redir_hit)     raw_next = arb_target;
      else if (pend_v_q) raw_next = pend_t_q;
      else               raw_next = pc_q + STEP;
   end

   assign pc_next     = raw_next & ~LOW_MASK;
   assign misalign_o  = commit && ((raw_next & LOW_MASK) != '0);
   assign redir_ack_o = redir_hit ? arb_grant : '0;
   assign pc_o        = pc_q;
   assign pc_next_o   = pc_next;

   // pc_o only moves on a commit, so it stays stable while ISSUE waits.
   // A redirect consumed by the commit itself is not kept as pending.
   always_comb begin
      pc_d     = pc_q;
      pend_v_d = pend_v_q;
      pend_t_d = pend_t_q;
      if (commit) begin
         pc_d     = pc_next;
         pend_v_d = 1'b0;
      end else if (redir_hit) begin
         pend_v_d = 1'b1;
         pend_t_d = arb_target;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         pend_v_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         pend_v_q <= pend_v_d;
      end
   end

   // Target payload only matters while pend_v_q is set.
   always_ff @(posedge clock) begin
      pend_t_q <= pend_t_d;
   end

endmodule

// File: tb/tb_ysyx_23060025_pc_gen.sv
module tb_ysyx_23060025_pc_gen;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  redir_valid_i;
   logic [95:0] redir_target_i;
   logic [2:0]  redir_ack_o;
   logic        fetch_valid_o;
   logic        fetch_ready_i;
   logic        fetch_done_i;
   logic [31:0] pc_o;
   logic [31:0] pc_next_o;
   logic        misalign_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   ysyx_23060025_pc_gen dut (
      .clock          (clock),
      .reset          (reset),
      .redir_valid_i  (redir_valid_i),
      .redir_target_i (redir_target_i),
      .redir_ack_o    (redir_ack_o),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_ready_i  (fetch_ready_i),
      .fetch_done_i   (fetch_done_i),
      .pc_o           (pc_o),
      .pc_next_o      (pc_next_o),
      .misalign_o     (misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model: a fetch lifecycle described by "started" (past the
   // post-reset hold cycle) and "issuing" (offering a PC vs. awaiting done).
   bit          m_known   = 0;
   bit          m_started = 0;
   bit          m_issuing = 0;
   logic [31:0] m_pc      = '0;
   bit          m_pend_v  = 0;
   logic [31:0] m_pend_t  = '0;

   // Per-cycle values computed in drive() and consumed by adv().
   logic [31:0] tg [3];
   bit          c_rn, c_rdy, c_commit, c_hit;
   logic [31:0] c_next, c_win_t;

   task automatic drive(input logic [2:0] rv, input logic [31:0] t0, input logic [31:0] t1,
                        input logic [31:0] t2, input logic rdy, input logic dn, input logic rn);
      int          win;
      bit          active;
      logic [31:0] raw;
      logic [2:0]  exp_ack;
      @(negedge clock);
      redir_valid_i  = rv;
      redir_target_i = {t2, t1, t0};
      fetch_ready_i  = rdy;
      fetch_done_i   = dn;
      reset          = rn;
      tg[0] = t0; tg[1] = t1; tg[2] = t2;
      #1;
      win = -1;
      for (int k = 0; k < 3; k++) if (rv[k] && win < 0) win = k;
      active   = rn && m_started;
      c_hit    = active && (win >= 0);
      c_win_t  = c_hit ? tg[win] : 32'h0;
      c_commit = rn && m_started && !m_issuing && dn;
      if (c_hit)         raw = c_win_t;
      else if (m_pend_v) raw = m_pend_t;
      else               raw = m_pc + 32'd4;
      c_next  = (raw >> 2) << 2;
      exp_ack = c_hit ? (3'b001 << win) : 3'b000;
      c_rn  = rn;
      c_rdy = rdy;
      if (m_known) begin
         chk("valid",    {31'd0, fetch_valid_o}, {31'd0, m_started && m_issuing});
         chk("pc",       pc_o, m_pc);
         chk("pc_next",  pc_next_o, c_next);
         chk("ack",      {29'd0, redir_ack_o}, {29'd0, exp_ack});
         chk("misalign", {31'd0, misalign_o}, {31'd0, c_commit && (raw % 4 != 0)});
      end
   endtask

   task automatic adv();
      @(posedge clock);
      if (!c_rn) begin
         m_known   = 1;
         m_started = 0;
         m_pc      = RST_PC;
         m_pend_v  = 0;
      end else if (!m_started) begin
         m_started = 1;
         m_issuing = 1;
      end else begin
         if (c_hit && !c_commit) begin
            m_pend_v = 1;
            m_pend_t = c_win_t;
         end
         if (c_commit) begin
            m_pc      = c_next;
            m_pend_v  = 0;
            m_issuing = 1;
         end else if (m_issuing && c_rdy) begin
            m_issuing = 0;
         end
      end
      #2;
   endtask

   task automatic step(input logic rdy, input logic dn);
      drive(3'b000, 32'h0, 32'h0, 32'h0, rdy, dn, 1'b1);
      adv();
   endtask

   initial begin
      redir_valid_i  = '0;
      redir_target_i = '0;
      fetch_ready_i  = 1'b0;
      fetch_done_i   = 1'b0;
      reset          = 1'b0;

      // Reset and sequential flow
      drive(3'b000, 0, 0, 0, 1'b0, 1'b0, 1'b0); adv();
      drive(3'b000, 0, 0, 0, 1'b0, 1'b0, 1'b0); adv();
      chk("rst_pc",    pc_o, RST_PC);
      chk("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("rst_ack",   {29'd0, redir_ack_o}, 32'd0);
      chk("rst_mis",   {31'd0, misalign_o}, 32'd0);
      step(1'b1, 1'b1);
      chk("hold_1cyc", {31'd0, fetch_valid_o}, 32'd1);
      chk("seq0", pc_o, 32'h8000_0000);
      step(1'b1, 1'b1); step(1'b1, 1'b1);
      chk("seq1", pc_o, 32'h8000_0004);
      step(1'b1, 1'b1); step(1'b1, 1'b1);
      chk("seq2", pc_o, 32'h8000_0008);

      // Two requests in the done cycle: channel 1 wins
      step(1'b1, 1'b0);
      drive(3'b110, 32'h0, 32'h8000_1000, 32'h8000_2000, 1'b1, 1'b1, 1'b1);
      chk("prio_ack", {29'd0, redir_ack_o}, 32'd2);
      adv();
      chk("prio_pc", pc_o, 32'h8000_1000);

      // Redirect during ISSUE is held until the fetch completes
      drive(3'b100, 32'h0, 32'h0, 32'h8000_3000, 1'b0, 1'b0, 1'b1); adv();
      chk("issue_stable", pc_o, 32'h8000_1000);
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
      step(1'b0, 1'b0); step(1'b0, 1'b1);
      chk("pend_commit", pc_o, 32'h8000_3000);
      step(1'b1, 1'b0); step(1'b0, 1'b1);
      chk("pend_clear", pc_o, 32'h8000_3004);

      // Live redirect overrides a pending one
      drive(3'b100, 32'h0, 32'h0, 32'h8000_3000, 1'b1, 1'b0, 1'b1); adv();
      drive(3'b001, 32'h8000_4000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1); adv();
      chk("override", pc_o, 32'h8000_4000);
      step(1'b1, 1'b0); step(1'b0, 1'b1);
      chk("override_next", pc_o, 32'h8000_4004);

      // Address wrap
      drive(3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1); adv();
      step(1'b0, 1'b1);
      chk("top_pc", pc_o, 32'hFFFF_FFFC);
      step(1'b1, 1'b0); step(1'b0, 1'b1);
      chk("wrap", pc_o, 32'h0000_0000);

      // Misaligned target
      step(1'b1, 1'b0);
      drive(3'b010, 32'h0, 32'h8000_0006, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      chk("mis_next", pc_next_o, 32'h8000_0004);
      adv();
      chk("mis_pc", pc_o, 32'h8000_0004);
      drive(3'b000, 0, 0, 0, 1'b1, 1'b0, 1'b1);
      chk("mis_drop", {31'd0, misalign_o}, 32'd0);
      adv();

      // Reset in WAIT drops the pending redirect
      drive(3'b010, 32'h0, 32'h8000_5000, 32'h0, 1'b0, 1'b0, 1'b1); adv();
      drive(3'b000, 0, 0, 0, 1'b0, 1'b0, 1'b0); adv();
      chk("mid_rst_pc", pc_o, RST_PC);
      chk("mid_rst_valid", {31'd0, fetch_valid_o}, 32'd0);
      step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      chk("mid_rst_drop", pc_o, 32'h8000_0004);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [2:0]  rv;
         logic [31:0] t [3];
         for (int k = 0; k < 3; k++) begin
            t[k] = $urandom;
            if ($urandom_range(3) != 0) t[k][1:0] = 2'b00;
            rv[k] = ($urandom_range(7) == 0);
         end
         drive(rv, t[0], t[1], t[2], 1'($urandom_range(1)), 1'($urandom_range(1)),
               ($urandom_range(63) != 0));
         adv();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
